// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: baud decode, frame sequencing and load/ready handshake.
// Optional UART_TX_TWO_STOP_EN: two stop bits per frame instead of one.
module uart_tx_ctrl #(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  baud_sel,
  input  logic        eight,
  input  logic        parity_en,
  input  logic        odd_n_even,
  input  logic        load,
  input  logic [7:0]  data_in,
  input  logic        btu,
  output logic        do_it,
  output logic [19:0] k,
  output logic        tx,
  output logic        tx_rdy,
  output logic        tx_done
);

  // state  | meaning
  // IDLE   | line high, ready for load, k tracks baud_sel
  // START  | start bit (0)
  // DATA   | data bits, LSB first
  // PARITY | parity bit over the data bits
  // STOP   | stop bit(s) (1), tx_done on exit
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        eight_q, eight_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic [19:0] k_q, k_d;
  logic        tx_q, tx_d;
  logic        tx_rdy_q, tx_rdy_d;
  logic        do_it_q, do_it_d;
  logic        tx_done_q, tx_done_d;
  logic [2:0]  last_bit;
  logic        data_b7;
`ifdef UART_TX_TWO_STOP_EN
  logic        stop_cnt_q, stop_cnt_d;
`endif

  // Terminal count is the bit period in clocks, rounded to nearest.
  function automatic logic [19:0] div_k(input int baud);
    return 20'((CLK_HZ + baud / 2) / baud);
  endfunction

  function automatic logic [19:0] baud_k(input logic [3:0] sel);
    logic [19:0] kv;
    case (sel)
      4'd0:    kv = div_k(300);
      4'd1:    kv = div_k(1200);
      4'd2:    kv = div_k(2400);
      4'd3:    kv = div_k(4800);
      4'd4:    kv = div_k(9600);
      4'd5:    kv = div_k(19200);
      4'd6:    kv = div_k(38400);
      4'd7:    kv = div_k(57600);
      4'd8:    kv = div_k(115200);
      4'd9:    kv = div_k(230400);
      4'd10:   kv = div_k(460800);
      4'd11:   kv = div_k(921600);
      default: kv = div_k(115200);
    endcase
    return kv;
  endfunction

  assign data_b7  = eight & data_in[7];
  assign last_bit = eight_q ? 3'd7 : 3'd6;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    eight_d   = eight_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    k_d       = k_q;
    tx_done_d = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif
    if (state_q == S_IDLE) k_d = baud_k(baud_sel);

    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = {data_b7, data_in[6:0]};
          eight_d   = eight;
          par_en_d  = parity_en;
          par_bit_d = (^data_in[6:0]) ^ data_b7 ^ odd_n_even;
          bit_cnt_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (btu) begin
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (btu) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d = 3'd0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (btu) state_d = S_STOP;
      end
      S_STOP: begin
        if (btu) begin
`ifdef UART_TX_TWO_STOP_EN
          if (stop_cnt_q) begin
            stop_cnt_d = 1'b0;
            tx_done_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
`else
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line outputs follow the next state so they switch on the transition edge.
    tx_d     = 1'b1;
    tx_rdy_d = 1'b0;
    do_it_d  = 1'b1;
    case (state_d)
      S_IDLE: begin
        tx_rdy_d = 1'b1;
        do_it_d  = 1'b0;
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      eight_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      k_q       <= 20'd333333;
      tx_q      <= 1'b1;
      tx_rdy_q  <= 1'b1;
      do_it_q   <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      eight_q   <= eight_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      k_q       <= k_d;
      tx_q      <= tx_d;
      tx_rdy_q  <= tx_rdy_d;
      do_it_q   <= do_it_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  assign do_it   = do_it_q;
  assign k       = k_q;
  assign tx      = tx_q;
  assign tx_rdy  = tx_rdy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level model checked every cycle, plus literal frame checks.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  baud_sel = 4'd8;
  logic        eight = 1'b1;
  logic        parity_en = 1'b0;
  logic        odd_n_even = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        btu_inj = 1'b0;
  logic        btu;
  logic        do_it;
  logic [19:0] k;
  logic        tx;
  logic        tx_rdy;
  logic        tx_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_HZ(100000000)) dut (
    .clk(clk), .reset(reset), .baud_sel(baud_sel), .eight(eight),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .load(load),
    .data_in(data_in), .btu(btu), .do_it(do_it), .k(k), .tx(tx),
    .tx_rdy(tx_rdy), .tx_done(tx_done)
  );

  // Bit-time counter: counts 0..k while enabled, btu at count k.
  logic [19:0] bt_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) bt_cnt <= 20'd0;
    else if (!do_it) bt_cnt <= 20'd0;
    else if (bt_cnt == k) bt_cnt <= 20'd0;
    else bt_cnt <= bt_cnt + 20'd1;
  end
  assign btu = (do_it && (bt_cnt == k)) || btu_inj;

  function automatic int k_of(input logic [3:0] s);
    case (s)
      4'd0: return 333333;  4'd1: return 83333;  4'd2: return 41667;
      4'd3: return 20833;   4'd4: return 10417;  4'd5: return 5208;
      4'd6: return 2604;    4'd7: return 1736;   4'd8: return 868;
      4'd9: return 434;     4'd10: return 217;   4'd11: return 109;
      default: return 868;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame model: a frame is a list of bits, each held for k+1 clocks after the accepting edge.
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_t = 0;
  int   m_per = 1;
  int   m_nbits = 0;
  int   m_k = 333333;
  logic m_bits [0:15];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_t    = 0;
      m_k    = 333333;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_t++;
        if (m_t == m_nbits * m_per) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        m_k = k_of(baud_sel);
        if (load) begin
          logic p;
          int   n;
          n = eight ? 8 : 7;
          p = odd_n_even;
          m_nbits = 0;
          m_bits[m_nbits++] = 1'b0;
          for (int i = 0; i < n; i++) begin
            m_bits[m_nbits++] = data_in[i];
            p = p ^ data_in[i];
          end
          if (parity_en) m_bits[m_nbits++] = p;
          for (int s = 0; s < NSTOP; s++) m_bits[m_nbits++] = 1'b1;
          m_per  = m_k + 1;
          m_t    = 0;
          m_busy = 1'b1;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    cyc++;
    chk("tx", tx, m_busy ? m_bits[m_t / m_per] : 1'b1);
    chk("tx_rdy", tx_rdy, !m_busy);
    chk("do_it", do_it, m_busy);
    chk("tx_done", tx_done, m_done);
    chk("k", k, m_k);
  end

  always @(negedge clk) if (tx_done) n_done++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] bs, input logic e8, input logic pe,
                      input logic odd, input logic [7:0] d);
    @(negedge clk);
    baud_sel = bs; eight = e8; parity_en = pe; odd_n_even = odd; data_in = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Starts at the accepting edge +1; samples each bit mid-period; ends one clock after tx_done.
  task automatic run_frame(input string nm, input int base_nb, input int per,
                           input logic [15:0] exp1, input int act_bit, input int mode,
                           input logic b2b, input logic [7:0] nxt);
    int nb;
    int h;
    int d0;
    logic [15:0] expb;
    logic [15:0] got;
    nb = base_nb + NSTOP - 1;
    h = per / 2;
    d0 = n_done;
    expb = exp1;
    got = '0;
    for (int b = base_nb; b < nb; b++) expb[b] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      tick(h);
      got[b] = tx;
      if (b == act_bit) begin
        if (mode == 1) begin
          baud_sel = 4'd0; data_in = 8'h3C; eight = 1'b1;
          parity_en = 1'b0; odd_n_even = ~odd_n_even;
        end else begin
          data_in = 8'hFF; load = 1'b1;
        end
        tick(1);
        load = 1'b0;
        tick(per - h - 1);
      end else begin
        tick(per - h);
      end
    end
    chk({nm, " bits"}, got, expb);
    chk({nm, " done"}, tx_done, 1);
    chk({nm, " rdy"}, tx_rdy, 1);
    if (b2b) begin
      data_in = nxt;
      load = 1'b1;
    end
    tick(1);
    load = 1'b0;
    chk({nm, " done count"}, n_done - d0, 1);
    chk({nm, " done width"}, tx_done, 0);
    if (b2b) begin
      chk({nm, " b2b tx"}, tx, 0);
      chk({nm, " b2b rdy"}, tx_rdy, 0);
    end
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    tick(3);
    chk("rst tx", tx, 1);
    chk("rst rdy", tx_rdy, 1);
    chk("rst k", k, 333333);
    reset = 1'b0;
    tick(2);

    send(4'd8, 1'b1, 1'b0, 1'b0, 8'h55);
    run_frame("A_8N_55", 10, 869, 16'h02AA, -1, 0, 1'b0, 8'h00);

    d0 = n_done;
    send(4'd8, 1'b1, 1'b0, 1'b0, 8'h55);
    tick(3 * 869 + 100);
    reset = 1'b1;
    #1;
    chk("midrst tx", tx, 1);
    chk("midrst rdy", tx_rdy, 1);
    chk("midrst do_it", do_it, 0);
    chk("midrst done", tx_done, 0);
    chk("midrst k", k, 333333);
    tick(2);
    reset = 1'b0;
    #1;
    chk("k held after rst", k, 333333);
    tick(1);
    chk("k reload", k, 868);
    chk("midrst no done", n_done - d0, 0);

    send(4'd11, 1'b0, 1'b1, 1'b0, 8'hC3);
    run_frame("B_7E_C3", 10, 110, 16'h0386, -1, 0, 1'b0, 8'h00);

    send(4'd11, 1'b0, 1'b1, 1'b1, 8'hC3);
    run_frame("C_7O_C3_toggle", 10, 110, 16'h0286, 3, 1, 1'b0, 8'h00);

    send(4'd11, 1'b1, 1'b0, 1'b0, 8'hA5);
    run_frame("D_ignored_load", 10, 110, 16'h034A, 4, 2, 1'b1, 8'h0F);
    run_frame("E_back_to_back", 10, 110, 16'h021E, -1, 0, 1'b0, 8'h00);

    tick(3);
    btu_inj = 1'b1;
    tick(1);
    btu_inj = 1'b0;
    chk("idle btu tx", tx, 1);
    chk("idle btu rdy", tx_rdy, 1);
    chk("idle btu do_it", do_it, 0);
    tick(3);

`ifdef UART_TX_TWO_STOP_EN
    send(4'd9, 1'b1, 1'b0, 1'b0, 8'h55);
    run_frame("F_two_stop", 10, 435, 16'h02AA, -1, 0, 1'b0, 8'h00);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
